// File: rtl/sar_value_finder_pkg.sv
// Shared types and defaults for the successive-approximation value finder.
package sar_value_finder_pkg;

  localparam int SAR_WIDTH = 8;
  localparam int SAR_CNTW  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_FIN   = 2'd2
  } sar_state_e;

endpackage

// File: rtl/sar_value_finder_if.sv
// Search control/result bundle between the value finder and its comparator-side environment.
interface sar_value_finder_if
  import sar_value_finder_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH,
  parameter int CNTW  = SAR_CNTW
);

  logic             start;
  logic             gt_in;
  logic             eq_in;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [CNTW-1:0]  probes;

  // The finder side.
  modport master (
    input  start, gt_in, eq_in,
    output guess, busy, done, result, probes
  );

  // The environment: requester plus external comparator.
  modport slave (
    output start, gt_in, eq_in,
    input  guess, busy, done, result, probes
  );

endinterface

// File: rtl/sar_value_finder.sv
// Recovers an unknown value MSB-first from an external comparator's greater/equal answers.
module sar_value_finder
  import sar_value_finder_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH,
  parameter int CNTW  = SAR_CNTW
) (
  input  logic               clk,
  input  logic               rst,
  sar_value_finder_if.master bus
);

  sar_state_e       state_reg, state_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [CNTW-1:0]  bit_reg, bit_next;
  logic [CNTW-1:0]  cnt_reg, cnt_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [CNTW-1:0]  probes_reg, probes_next;

  logic [WIDTH-1:0] probe;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;

  // Trial value: accumulated bits plus the one currently under test.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_probe
      assign probe[gi] = acc_reg[gi] | (bit_reg == CNTW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      acc_reg    <= '0;
      bit_reg    <= CNTW'(WIDTH - 1);
      cnt_reg    <= '0;
      result_reg <= '0;
      probes_reg <= '0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      bit_reg    <= bit_next;
      cnt_reg    <= cnt_next;
      result_reg <= result_next;
      probes_reg <= probes_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    bit_next    = bit_reg;
    cnt_next    = cnt_reg;
    result_next = result_reg;
    probes_next = probes_reg;
    guess       = result_reg;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          state_next = S_PROBE;
          acc_next   = '0;
          bit_next   = CNTW'(WIDTH - 1);
          cnt_next   = '0;
        end
      end

      S_PROBE: begin
        busy     = 1'b1;
        guess    = probe;
        cnt_next = cnt_reg + CNTW'(1);
        // Equality wins even if the comparator also claims greater-than.
        if (bus.eq_in) begin
          result_next = probe;
          probes_next = cnt_reg + CNTW'(1);
          state_next  = S_FIN;
        end else begin
          if (bus.gt_in) begin
            acc_next = probe;
          end
          if (bit_reg == '0) begin
            result_next = bus.gt_in ? probe : acc_reg;
            probes_next = CNTW'(WIDTH);
            state_next  = S_FIN;
          end else begin
            bit_next = bit_reg - CNTW'(1);
          end
        end
      end

      S_FIN: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.guess  = guess;
  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result_reg;
  assign bus.probes = probes_reg;

endmodule

// File: tb/tb_sar_value_finder.sv
// Scoreboard bench: a behavioural comparator answers the finder's guesses for a hidden target.
module tb_sar_value_finder;
  import sar_value_finder_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] target;
  int         cycle = 0;
  int         tests = 0;
  int         fails = 0;
  int         done_seen = 0;

  typedef struct {
    logic [7:0] res;
    logic [3:0] prb;
    int         issue;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] guess_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  sar_value_finder_if #(.WIDTH(8), .CNTW(4)) bus ();

  assign bus.gt_in = (target > bus.guess);
  assign bus.eq_in = (target == bus.guess);

  sar_value_finder #(.WIDTH(8), .CNTW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (target %0h, cycle %0d)", name, act, exp, target, cycle);
    end
  endtask

  function automatic logic [3:0] exp_probes(input logic [7:0] t);
    if (t == 8'd0) return 4'd8;
    for (int i = 0; i < 8; i++)
      if (t[i]) return 4'(8 - i);
    return 4'd8;
  endfunction

  // Monitor: checks guess traces and pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy && guess_q.size() > 0) begin
        logic [7:0] g;
        g = guess_q.pop_front();
        check("guess", 32'(bus.guess), 32'(g));
      end
      if (bus.done) begin
        done_seen++;
        check("busy_during_done", 32'(bus.busy), 32'd0);
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done with no pending search (result %0h)", bus.result);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("result", 32'(bus.result), 32'(e.res));
          check("probes", 32'(bus.probes), 32'(e.prb));
          check("latency", 32'(cycle - e.issue), 32'(e.prb) + 32'd1);
        end
      end
    end
  end

  task automatic start_search(input logic [7:0] t, input logic [3:0] p);
    @(posedge clk);
    #1;
    target = t;
    sb_q.push_back('{res: t, prb: p, issue: cycle});
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() > 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: no done within 40 cycles for target %0h", target);
      sb_q.delete();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_guess"},  32'(bus.guess),  32'd0);
    check({tag, "_busy"},   32'(bus.busy),   32'd0);
    check({tag, "_done"},   32'(bus.done),   32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'd0);
    check({tag, "_probes"}, 32'(bus.probes), 32'd0);
  endtask

  initial begin
    logic [7:0] trace0[8];
    logic [7:0] trace255[8];
    int         d0;
    trace0   = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    trace255 = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

    rst       = 1'b1;
    bus.start = 1'b0;
    target    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;

    // Single probe: equality on the MSB trial.
    start_search(8'd128, 4'd1);
    wait_idle();
    $display("[TB] target 80 -> result %0h probes %0d", bus.result, bus.probes);

    // All-less-than path.
    for (int i = 0; i < 8; i++) guess_q.push_back(trace0[i]);
    start_search(8'd0, 4'd8);
    wait_idle();
    check("trace0_consumed", 32'(guess_q.size()), 32'd0);
    guess_q.delete();
    $display("[TB] target 00 -> result %0h probes %0d", bus.result, bus.probes);

    // All-ones: equality on the final probe.
    for (int i = 0; i < 8; i++) guess_q.push_back(trace255[i]);
    start_search(8'd255, 4'd8);
    wait_idle();
    check("trace255_consumed", 32'(guess_q.size()), 32'd0);
    guess_q.delete();
    $display("[TB] target FF -> result %0h probes %0d", bus.result, bus.probes);

    // Restart attempt mid-search must be ignored.
    d0 = done_seen;
    start_search(8'h5A, 4'd7);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("restart_done_count", 32'(done_seen - d0), 32'd1);
    check("restart_result_held", 32'(bus.result), 32'h5A);
    check("idle_guess_is_result", 32'(bus.guess), 32'h5A);
    $display("[TB] target 5A with restart -> result %0h probes %0d", bus.result, bus.probes);

    // Reset in the middle of a search.
    start_search(8'h37, 4'd8);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    check_zero_outputs("midreset");
    rst = 1'b0;
    start_search(8'h37, 4'd8);
    wait_idle();
    #1;
    check("post_reset_result", 32'(bus.result), 32'h37);
    $display("[TB] target 37 after reset -> result %0h probes %0d", bus.result, bus.probes);

    for (int t = 0; t < 256; t++) begin
      start_search(8'(t), exp_probes(8'(t)));
      wait_idle();
    end
    $display("[TB] exhaustive sweep of 256 targets complete");

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
    $fatal(1, "watchdog expired");
  end

endmodule
